// File: rtl/recog_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : recog_arbiter
// Purpose  : Round-robin sequencer sharing one pattern-recognizer engine.
// Revision : 1.0
// ============================================================================
module recog_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 6,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] word,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic              rsp_match,
    output logic              rsp_error,
    output logic              eng_start,
    output logic [W-1:0]      eng_word,
    input  logic              eng_done,
    input  logic              eng_match,
    output logic              busy
);

    localparam int c_PW = $clog2(NREQ);
    localparam int c_CW = $clog2(TIMEOUT + 1);
    localparam logic [c_PW-1:0] c_PTR_RST  = c_PW'(NREQ - 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state,  w_state_nxt;
    logic [c_PW-1:0]   r_ptr,    w_ptr_nxt;
    logic [c_PW-1:0]   r_owner,  w_owner_nxt;
    logic [c_CW-1:0]   r_cnt,    w_cnt_nxt;
    logic [W-1:0]      r_word,   w_word_nxt;
    logic [NREQ-1:0]   r_gnt,    w_gnt_nxt;
    logic [NREQ-1:0]   r_rsp,    w_rsp_nxt;
    logic              r_match,  w_match_nxt;
    logic              r_error,  w_error_nxt;
    logic              r_start,  w_start_nxt;
    logic              r_busy,   w_busy_nxt;

    logic              w_any_lo, w_any_hi, w_any;
    logic [c_PW-1:0]   w_win_lo, w_win_hi, w_win;
    logic [NREQ-1:0]   w_win_oh, w_owner_oh;
    logic [W-1:0]      w_word_sel;

    // Requesters above ptr outrank those at or below it; lowest index wins
    // within each half, giving the upward scan from ptr+1 with wrap-around.
    always_comb begin
        w_any_lo = 1'b0;
        w_any_hi = 1'b0;
        w_win_lo = '0;
        w_win_hi = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (c_PW'(i) <= r_ptr)) begin
                w_any_lo = 1'b1;
                w_win_lo = c_PW'(i);
            end
            if (req[i] && (c_PW'(i) > r_ptr)) begin
                w_any_hi = 1'b1;
                w_win_hi = c_PW'(i);
            end
        end
        w_any = w_any_lo | w_any_hi;
        w_win = w_any_hi ? w_win_hi : w_win_lo;
    end

    always_comb begin
        w_win_oh   = '0;
        w_owner_oh = '0;
        w_word_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_win_oh[i]   = (w_win == c_PW'(i));
            w_owner_oh[i] = (r_owner == c_PW'(i));
            if (w_win == c_PW'(i)) begin
                w_word_sel = word[i*W +: W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        w_match_nxt = r_match;
        w_error_nxt = r_error;
        w_gnt_nxt   = '0;
        w_rsp_nxt   = '0;
        w_start_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_ISSUE;
                    w_owner_nxt = w_win;
                    w_word_nxt  = w_word_sel;
                    w_gnt_nxt   = w_win_oh;
                    w_start_nxt = 1'b1;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = '0;
            end
            S_WAIT: begin
                // A verdict arriving on the last allowed cycle beats the timeout.
                if (eng_done) begin
                    w_state_nxt = S_RESP;
                    w_match_nxt = eng_match;
                    w_error_nxt = 1'b0;
                    w_rsp_nxt   = w_owner_oh;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_RESP;
                    w_match_nxt = 1'b0;
                    w_error_nxt = 1'b1;
                    w_rsp_nxt   = w_owner_oh;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = r_owner;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= c_PTR_RST;
            r_owner <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            r_gnt   <= '0;
            r_rsp   <= '0;
            r_match <= 1'b0;
            r_error <= 1'b0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
            r_gnt   <= w_gnt_nxt;
            r_rsp   <= w_rsp_nxt;
            r_match <= w_match_nxt;
            r_error <= w_error_nxt;
            r_start <= w_start_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp;
    assign rsp_match = r_match;
    assign rsp_error = r_error;
    assign eng_start = r_start;
    assign eng_word  = r_word;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_recog_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_recog_arbiter
// Purpose  : Directed scoreboard bench for recog_arbiter with an engine model.
// Revision : 1.0
// ============================================================================
module tb_recog_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 6;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] word;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic              rsp_match;
    logic              rsp_error;
    logic              eng_start;
    logic [W-1:0]      eng_word;
    logic              eng_done;
    logic              eng_match;
    logic              busy;

    always #5 clk = ~clk;

    recog_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .word      (word),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_match (rsp_match),
        .rsp_error (rsp_error),
        .eng_start (eng_start),
        .eng_word  (eng_word),
        .eng_done  (eng_done),
        .eng_match (eng_match),
        .busy      (busy)
    );

    typedef struct {
        int   idx;
        logic m;
        logic e;
    } exp_t;

    exp_t          sb[$];
    int            glog[$];
    logic [W-1:0]  wd [NREQ];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            mptr  = NREQ - 1;
    int            cd    = 0;
    int            issue_cyc = 0;
    int            done_cyc  = 0;
    int            rsp_cyc   = 0;
    int            t0        = 0;
    int            eng_lat   = 0;
    logic          eng_ans   = 1'b0;
    logic          exp_m     = 1'b0;
    logic          exp_e     = 1'b0;
    logic          force_done = 1'b0;
    logic [NREQ-1:0] rereq   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [NREQ-1:0] r, input int p);
        int res;
        res = -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (res < 0 && r[(p + k) % NREQ]) res = (p + k) % NREQ;
        end
        return res;
    endfunction

    // One clock: observe registered outputs at the falling edge, run the
    // engine/requester models, push on grant, pop and compare on response.
    task automatic step();
        logic [NREQ-1:0] req_s;
        exp_t            e;
        int              wi;
        req_s = req;
        @(negedge clk);
        cyc++;
        eng_done  = force_done;
        eng_match = force_done;
        if (gnt != '0) begin
            wi = rr(req_s, mptr);
            chk("gnt", gnt, (wi < 0) ? 32'd0 : (32'd1 << wi));
            if (wi >= 0) begin
                chk("eng_start", eng_start, 1);
                chk("eng_word", eng_word, wd[wi]);
                sb.push_back('{wi, exp_m, exp_e});
                glog.push_back(wi);
                req[wi]   = 1'b0;
                issue_cyc = cyc;
                cd        = eng_lat;
            end
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                eng_done  = 1'b1;
                eng_match = eng_ans;
                done_cyc  = cyc;
            end
        end
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("spurious_rsp", rsp_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", rsp_valid, 32'd1 << e.idx);
                chk("rsp_match", rsp_match, e.m);
                chk("rsp_error", rsp_error, e.e);
                mptr    = e.idx;
                rsp_cyc = cyc;
                if (rereq[e.idx]) req[e.idx] = 1'b1;
            end
        end
    endtask

    task automatic drain(input string tag, input int maxc);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(sb.size() == 0 && req == '0 && !busy) && n < maxc);
        if (n >= maxc) begin
            total++;
            bad++;
            $error("FAIL %s_bound: observed=busy expected=idle within %0d cycles", tag, maxc);
        end
    endtask

    initial begin
        req       = '0;
        eng_done  = 1'b0;
        eng_match = 1'b0;
        wd[0] = 6'b101101;
        wd[1] = 6'b010011;
        wd[2] = 6'b100000;
        wd[3] = 6'b111000;
        for (int i = 0; i < NREQ; i++) word[i*W +: W] = wd[i];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_match", rsp_match, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_word", eng_word, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Single request, match after 7 cycles
        eng_lat = 7; eng_ans = 1'b1; exp_m = 1'b1; exp_e = 1'b0;
        t0 = cyc;
        req = 4'b0001;
        drain("single", 60);
        chk("single_grants", glog.size(), 1);
        chk("single_issue_lat", issue_cyc - t0, 1);
        chk("single_done_to_rsp", rsp_cyc - done_cyc, 1);

        // Mismatch verdict
        eng_lat = 3; eng_ans = 1'b0; exp_m = 1'b0; exp_e = 1'b0;
        req = 4'b0100;
        drain("mismatch", 60);
        chk("mismatch_grants", glog.size(), 2);

        // Timeout: engine silent
        eng_lat = 0; exp_m = 1'b0; exp_e = 1'b1;
        t0 = cyc;
        req = 4'b0010;
        drain("timeout", 60);
        chk("timeout_lat_from_arb_edge", rsp_cyc - t0, TIMEOUT + 2);
        force_done = 1'b1;
        repeat (3) step();
        force_done = 1'b0;
        step();
        chk("idle_done_busy", busy, 0);
        chk("idle_done_gnt", gnt, 0);
        chk("idle_done_error_held", rsp_error, 1);
        chk("idle_done_match_held", rsp_match, 0);

        // Done coincides with the last timeout cycle
        eng_lat = TIMEOUT; eng_ans = 1'b1; exp_m = 1'b1; exp_e = 1'b0;
        req = 4'b1000;
        drain("collision", 60);
        chk("collision_rsp_lat", rsp_cyc - issue_cyc, TIMEOUT + 1);

        // Reset in the middle of WAIT
        eng_lat = 0; exp_m = 1'b0; exp_e = 1'b1;
        req = 4'b0001;
        repeat (5) step();
        chk("pre_reset_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_eng_start", eng_start, 0);
        chk("midrst_gnt", gnt, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        sb.delete();
        glog.delete();
        mptr = NREQ - 1;
        cd   = 0;
        @(negedge clk);
        rst = 1'b0;

        // Round-robin fairness with continuous demand
        eng_lat = 2; eng_ans = 1'b1; exp_m = 1'b1; exp_e = 1'b0;
        rereq = 4'b1111;
        req   = 4'b1111;
        for (int n = 0; n < 200 && glog.size() < 5; n++) step();
        rereq = '0;
        drain("fair", 200);
        chk("fair_count", (glog.size() >= 5) ? 1 : 0, 1);
        if (glog.size() >= 5) begin
            chk("fair_g0", glog[0], 0);
            chk("fair_g1", glog[1], 1);
            chk("fair_g2", glog[2], 2);
            chk("fair_g3", glog[3], 3);
            chk("fair_g4", glog[4], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
